shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares the single combinational 32-bit barrel shifter between two requesters:
//   port 0 = EX-stage ALU shift ops (SLL/SRL/SRA and variable forms);
//   port 1 = MEM-stage load/store byte/half alignment.
//  Drives the shifter's data/shift/select inputs and captures its result.
//  Returns the result one cycle after grant through a registered response port tagged with requester id.
// PARAMETERS
//  DATA_W        32  operand/result width
//  SHAMT_W       6   shift-amount width; values >= DATA_W saturate
//  TAG_W         5   opaque requester tag (dest reg no.), returned unchanged
//  STARVE_LIMIT  4   consecutive port-1 losses before port 1 is forced priority
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  req0_valid  in   1        port 0 request valid
//  req0_ready  out  1        port 0 accepted this cycle when valid&ready
//  req0_data   in   DATA_W   port 0 operand
//  req0_shamt  in   SHAMT_W  port 0 shift amount
//  req0_sel    in   2        port 0 op: 00/01 SLL, 10 SRL, 11 SRA (01 see CONFIGURATION)
//  req0_tag    in   TAG_W    port 0 tag
//  req1_*      --   --       identical set for port 1
//  rsp_valid   out  1        response valid
//  rsp_ready   in   1        consumer accepts response
//  rsp_data    out  DATA_W   shift result
//  rsp_id      out  1        granted port (0/1)
//  rsp_tag     out  TAG_W    tag of granted request
//  sh_data     out  DATA_W   to shifter data input
//  sh_shift    out  SHAMT_W  to shifter shift input
//  sh_select   out  2        to shifter select input
//  sh_out      in   DATA_W   from shifter output (combinational)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, starve_cnt=0, state=IDLE; req*_ready=0 while rst_n=0.
//  - Slot free when !rsp_valid || rsp_ready; a grant is issued only in IDLE with slot free.
//  - Grant: port 0 wins by default; port 1 wins if port 0 is idle or starve_cnt==STARVE_LIMIT.
//  - starve_cnt: +1 when port 1 is valid and loses; clears on a port-1 grant; saturates at STARVE_LIMIT.
//  - Ready: req*_ready asserted only to the winner (combinational from valids/state/slot).
//  - Shifter inputs: sh_* are muxed from the winner; sh_out is registered into rsp_data the same edge.
//  - Latency 1 cycle: accept at edge N, rsp_valid high after edge N.
//  - rsp_* is held stable while rsp_valid && !rsp_ready.
//  - Back-to-back: a new grant may occur on the same edge the response is consumed; full throughput.
//  - Arithmetic: shamt >= 32 gives 0 for SLL/SRL and {32{data[31]}} for SRA; shamt=0 passes data through.
//  - Reset mid-operation: in-flight response and any rotate pass are discarded; no partial output.
//  - FSM: IDLE -> ROT2 only with rotate (below); otherwise stays in IDLE.
// CONFIGURATION
//  SHIFT_ARB_ROTATE_EN defined:
//   - sel=01 is ROL, executed as two shifter passes, rotate amount = shamt mod 32.
//   - IDLE cycle: pass 1 computes data<<n into a scratch register; state goes to ROT2.
//   - ROT2 cycle: pass 2 computes data>>(32-n) with SRL; rsp_data = scratch | sh_out.
//   - Both ports' ready are low during ROT2; latency is 2 cycles.
//   - n==0 completes in ROT2 with rsp_data=data.
//  SHIFT_ARB_ROTATE_EN undefined:
//   - sel=01 is treated as SLL; the ROT2 state and scratch register are absent.
// STRUCTURE
//  - Shared package shift_arb_pkg: sel encodings (SEL_SLL/SEL_SRL/SEL_SRA/SEL_ROL) and FSM state constants (ST_IDLE, ST_ROT2).
//  - Sub-module shift_arb_pick: grant logic plus starvation counter.
//  - The shifter stays outside this block, connected through the sh_* ports.
// TESTING
//  - Port 0 only: data=0x8000_0001, shamt=4, sel=11 -> next cycle rsp_data=0xF800_0000, rsp_id=0, tag echoed.
//  - Both valid every cycle, rsp_ready=1: grants go 0,0,0,0,1,0,... (port 1 wins once per STARVE_LIMIT+1 cycles).
//  - rsp_ready=0 for 3 cycles with response pending: rsp_* stable, both ready=0, no grant; grant resumes on release.
//  - Saturation: SRL shamt=40 data=0xFFFF_FFFF -> 0; SRA shamt=63 data=0x8000_0000 -> 0xFFFF_FFFF.
//  - With SHIFT_ARB_ROTATE_EN: ROL data=0x8000_0001 shamt=1 -> 0x0000_0003 after 2 cycles, ready low in ROT2.
//  - rst_n pulsed low during ROT2 -> rsp_valid=0 immediately; no response emitted after release.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared encodings for the shift-unit arbiter: shifter select codes and FSM states.
// The rotate state is only entered when SHIFT_ARB_ROTATE_EN is defined.
package shift_arb_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int SHAMT_W_DEF      = 6;
    localparam int TAG_W_DEF        = 5;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [1:0] SEL_SLL = 2'b00;
    localparam logic [1:0] SEL_ROL = 2'b01;
    localparam logic [1:0] SEL_SRL = 2'b10;
    localparam logic [1:0] SEL_SRA = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ROT2 = 1'b1
    } state_e;

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Request, response and external-shifter signals of the shift-unit arbiter.
// slave = the arbiter; master = requesters, response consumer and the shifter.
interface shift_unit_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 6,
    parameter int TAG_W   = 5
);
    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_data;
    logic [SHAMT_W-1:0] req0_shamt;
    logic [1:0]         req0_sel;
    logic [TAG_W-1:0]   req0_tag;

    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_data;
    logic [SHAMT_W-1:0] req1_shamt;
    logic [1:0]         req1_sel;
    logic [TAG_W-1:0]   req1_tag;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_id;
    logic [TAG_W-1:0]   rsp_tag;

    logic [DATA_W-1:0]  sh_data;
    logic [SHAMT_W-1:0] sh_shift;
    logic [1:0]         sh_select;
    logic [DATA_W-1:0]  sh_out;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_sel, req0_tag,
        output req0_ready,
        input  req1_valid, req1_data, req1_shamt, req1_sel, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_tag,
        input  rsp_ready,
        output sh_data, sh_shift, sh_select,
        input  sh_out
    );

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_sel, req0_tag,
        input  req0_ready,
        output req1_valid, req1_data, req1_shamt, req1_sel, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_tag,
        output rsp_ready,
        input  sh_data, sh_shift, sh_select,
        output sh_out
    );
endinterface

// File: rtl/shift_arb_pick.sv
// Two-port grant logic: port 0 preferred, port 1 forced after STARVE_LIMIT
// consecutive losses. Grants are combinational; only the loss counter is state.
module shift_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved;

    assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));
    assign gnt1_o  = grant_en_i && valid1_i && (!valid0_i || starved);
    assign gnt0_o  = grant_en_i && valid0_i && !gnt1_o;

    // A loss is only counted when a grant actually went to port 0.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt1_o) begin
            starve_cnt_d = '0;
        end else if (gnt0_o && valid1_i && !starved) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one external combinational barrel shifter between two requesters and
// returns a registered, tagged response. Optional ROL support: SHIFT_ARB_ROTATE_EN.
module shift_unit_arbiter
    import shift_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SHAMT_W      = SHAMT_W_DEF,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_unit_arbiter_if.slave  bus
);
    logic               slot_free, in_idle, grant_en;
    logic               gnt0, gnt1, any_gnt;
    logic [DATA_W-1:0]  w_data;
    logic [SHAMT_W-1:0] w_shamt;
    logic [1:0]         w_sel;
    logic [TAG_W-1:0]   w_tag;

    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

`ifdef SHIFT_ARB_ROTATE_EN
    localparam int NW = $clog2(DATA_W);
    state_e             state_q, state_d;
    logic [DATA_W-1:0]  scratch_q, scratch_d;
    logic [DATA_W-1:0]  rot_data_q, rot_data_d;
    logic [NW-1:0]      rot_n_q, rot_n_d;
    assign in_idle = (state_q == ST_IDLE);
`else
    assign in_idle = 1'b1;
`endif

    // Readies are forced low during reset even though the slot looks free.
    assign slot_free = !rsp_valid_q || bus.rsp_ready;
    assign grant_en  = rst_n && in_idle && slot_free;
    assign any_gnt   = gnt0 || gnt1;

    shift_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_en_i (grant_en),
        .valid0_i   (bus.req0_valid),
        .valid1_i   (bus.req1_valid),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1)
    );

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    assign w_data  = gnt1 ? bus.req1_data  : bus.req0_data;
    assign w_shamt = gnt1 ? bus.req1_shamt : bus.req0_shamt;
    assign w_sel   = gnt1 ? bus.req1_sel   : bus.req0_sel;
    assign w_tag   = gnt1 ? bus.req1_tag   : bus.req0_tag;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_id_d      = rsp_id_q;
        rsp_tag_d     = rsp_tag_q;
        bus.sh_data   = '0;
        bus.sh_shift  = '0;
        bus.sh_select = SEL_SLL;
`ifdef SHIFT_ARB_ROTATE_EN
        state_d    = state_q;
        scratch_d  = scratch_q;
        rot_data_d = rot_data_q;
        rot_n_d    = rot_n_q;
`endif
        if (slot_free) begin
            rsp_valid_d = 1'b0;
        end
`ifdef SHIFT_ARB_ROTATE_EN
        // Second rotate pass: n==0 shifts right by DATA_W, yielding zero.
        if (state_q == ST_ROT2) begin
            bus.sh_data   = rot_data_q;
            bus.sh_shift  = SHAMT_W'(DATA_W) - SHAMT_W'(rot_n_q);
            bus.sh_select = SEL_SRL;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = scratch_q | bus.sh_out;
            state_d       = ST_IDLE;
        end else
`endif
        if (any_gnt) begin
            bus.sh_data   = w_data;
            bus.sh_shift  = w_shamt;
            bus.sh_select = (w_sel == SEL_ROL) ? SEL_SLL : w_sel;
            rsp_id_d      = gnt1;
            rsp_tag_d     = w_tag;
`ifdef SHIFT_ARB_ROTATE_EN
            if (w_sel == SEL_ROL) begin
                bus.sh_shift = SHAMT_W'(w_shamt[NW-1:0]);
                scratch_d    = bus.sh_out;
                rot_data_d   = w_data;
                rot_n_d      = w_shamt[NW-1:0];
                state_d      = ST_ROT2;
            end else
`endif
            begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.sh_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
            state_q     <= ST_IDLE;
            scratch_q   <= '0;
            rot_data_q  <= '0;
            rot_n_q     <= '0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
`ifdef SHIFT_ARB_ROTATE_EN
            state_q     <= state_d;
            scratch_q   <= scratch_d;
            rot_data_q  <= rot_data_d;
            rot_n_q     <= rot_n_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed + random bench for shift_unit_arbiter with a behavioural barrel shifter
// and a response scoreboard; rotate steps are built when SHIFT_ARB_ROTATE_EN is defined.
module tb_shift_unit_arbiter;

    typedef struct packed {
        logic        id;
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic last_g0, last_g1;
    exp_t sb[$];

    shift_unit_arbiter_if #(.DATA_W(32), .SHAMT_W(6), .TAG_W(5)) bus ();

    shift_unit_arbiter #(.DATA_W(32), .SHAMT_W(6), .TAG_W(5), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External shifter as the real datapath would see it.
    always_comb begin
        case (bus.sh_select)
            2'b10:   bus.sh_out = bus.sh_data >> bus.sh_shift;
            2'b11:   bus.sh_out = 32'($signed(bus.sh_data) >>> bus.sh_shift);
            default: bus.sh_out = bus.sh_data << bus.sh_shift;
        endcase
    end

    function automatic logic [31:0] ref_op(input logic [31:0] d, input logic [5:0] s,
                                           input logic [1:0] sel);
        logic [31:0] r;
        int k;
        int sh;
        r  = '0;
        sh = int'(s);
        for (int i = 0; i < 32; i++) begin
            case (sel)
                2'b10: begin k = i + sh; r[i] = (k < 32) ? d[k[4:0]] : 1'b0; end
                2'b11: begin k = i + sh; r[i] = (k < 32) ? d[k[4:0]] : d[31]; end
`ifdef SHIFT_ARB_ROTATE_EN
                2'b01: begin k = (i - (sh % 32) + 32) % 32; r[i] = d[k[4:0]]; end
`endif
                default: begin k = i - sh; r[i] = (k >= 0) ? d[k[4:0]] : 1'b0; end
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] d,
                         input logic [5:0] s, input logic [1:0] sel, input logic [4:0] tag);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_shamt = s;
            bus.req0_sel = sel; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_shamt = s;
            bus.req1_sel = sel; bus.req1_tag = tag;
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        last_g0 = bus.req0_ready;
        last_g1 = bus.req1_ready;
        if (bus.rsp_valid && bus.rsp_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed=%0h expected=none", bus.rsp_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("rsp id=%0d tag=%0d data=%h", bus.rsp_id, bus.rsp_tag, bus.rsp_data);
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_id", bus.rsp_id, e.id);
                check("rsp_tag", bus.rsp_tag, e.tag);
            end
        end
        if (bus.req0_valid && last_g0)
            sb.push_back('{1'b0, bus.req0_tag, ref_op(bus.req0_data, bus.req0_shamt, bus.req0_sel)});
        if (bus.req1_valid && last_g1)
            sb.push_back('{1'b1, bus.req1_tag, ref_op(bus.req1_data, bus.req1_shamt, bus.req1_sel)});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b1, 32'h1234_5678, 6'd1, 2'b00, 5'd1);
        drive(1, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_ready0", bus.req0_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_tag", bus.rsp_tag, 0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // SRA basic, one-cycle latency
        drive(0, 1'b1, 32'h8000_0001, 6'd4, 2'b11, 5'd7);
        tick();
        check("lat_ready_seen", last_g0, 1);
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        check("sra_valid", bus.rsp_valid, 1);
        check("sra_data", bus.rsp_data, 32'hF800_0000);
        check("sra_id", bus.rsp_id, 0);
        check("sra_tag", bus.rsp_tag, 7);
        tick();

        // Saturation, back to back
        drive(0, 1'b1, 32'hFFFF_FFFF, 6'd40, 2'b10, 5'd2);
        tick();
        check("srl_sat", bus.rsp_data, 32'h0);
        drive(0, 1'b1, 32'h8000_0000, 6'd63, 2'b11, 5'd3);
        tick();
        check("sra_sat", bus.rsp_data, 32'hFFFF_FFFF);
        drive(0, 1'b1, 32'hA5A5_0F0F, 6'd0, 2'b00, 5'd4);
        tick();
        check("shamt0_pass", bus.rsp_data, 32'hA5A5_0F0F);
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);

        // Port 1 alone clears the starvation counter
        drive(1, 1'b1, 32'h0000_00F0, 6'd4, 2'b10, 5'd9);
        tick();
        check("p1_alone_grant", last_g1, 1);

        // Fairness: port 1 wins once every STARVE_LIMIT+1 grants
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, $urandom, 6'($urandom_range(0, 63)), (i % 2) ? 2'b10 : 2'b11, 5'(i));
            drive(1, 1'b1, $urandom, 6'($urandom_range(0, 63)), 2'b00, 5'(i + 16));
            tick();
            check("fair_g1", last_g1, (i % 5 == 4));
            check("fair_g0", last_g0, (i % 5 != 4));
        end

        // Back-pressure: response held, no grants
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_g0", last_g0, 0);
            check("stall_g1", last_g1, 0);
            check("stall_valid", bus.rsp_valid, 1);
            if (sb.size() != 0) check("stall_data", bus.rsp_data, sb[0].data);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("release_g0", last_g0, 1);
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        drive(1, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        tick();

`ifdef SHIFT_ARB_ROTATE_EN
        drive(0, 1'b1, 32'h8000_0001, 6'd1, 2'b01, 5'd5);
        tick();
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        drive(1, 1'b1, 32'h0000_0011, 6'd1, 2'b00, 5'd6);
        #1;
        check("rot2_ready0", bus.req0_ready, 0);
        check("rot2_ready1", bus.req1_ready, 0);
        check("rot2_valid", bus.rsp_valid, 0);
        tick();
        check("rol_valid", bus.rsp_valid, 1);
        check("rol_data", bus.rsp_data, 32'h0000_0003);
        drive(1, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        tick();
        drive(0, 1'b1, 32'hDEAD_BEEF, 6'd32, 2'b01, 5'd8);
        tick();
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        tick();
        check("rol_n0_data", bus.rsp_data, 32'hDEAD_BEEF);
        tick();
`endif

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            drive(1, 1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        drive(1, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
        tick();

        // Reset with a response pending
        drive(0, 1'b1, 32'h0000_0001, 6'd3, 2'b00, 5'd1);
        bus.rsp_ready = 1'b0;
        tick();
        check("pend_valid", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", bus.rsp_valid, 0);
        check("rst_ready0", bus.req0_ready, 0);
        sb.delete();
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();

`ifdef SHIFT_ARB_ROTATE_EN
        drive(0, 1'b1, 32'h8000_0001, 6'd1, 2'b01, 5'd5);
        tick();
        drive(0, 1'b0, 32'h0, 6'd0, 2'b00, 5'd0);
        rst_n = 1'b0;
        #1;
        check("rot_rst_valid", bus.rsp_valid, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_valid", bus.rsp_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
